// File: rtl/serial_rx_deser.sv
// serial_rx_deser: framed serial-to-parallel receiver with a valid/ready word output and sticky error flags.
module serial_rx_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sin,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q & ~dout_ready;
        ferr_d  = clr_err ? 1'b0 : ferr_q;
        ovr_d   = clr_err ? 1'b0 : ovr_q;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    state_d = sin ? IDLE : DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    sh_d    = LSB_FIRST ? {sin, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], sin};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(WIDTH - 1)) ? STOP : DATA;
                end
                STOP: begin
                    state_d = sin ? IDLE : BREAK;
                    ferr_d  = ~sin | ferr_d;
                    // A word consumed on this very edge frees the slot for the new one.
                    if (sin && (!valid_q || dout_ready)) begin
                        dout_d  = sh_q;
                        valid_d = 1'b1;
                    end else if (sin) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = sin ? IDLE : BREAK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= state_d != IDLE;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_serial_rx_deser.sv
// tb_serial_rx_deser: directed checks of both bit orders, handshake, overrun, framing error and reset.
module tb_serial_rx_deser;
    logic       clk = 1'b0, rst = 1'b0, bit_en = 1'b0, sin = 1'b1, clr_err = 1'b0, dout_ready = 1'b0;
    logic [7:0] dout_l, dout_m;
    logic       valid_l, busy_l, ferr_l, ovr_l, valid_m, busy_m, ferr_m, ovr_m;
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    serial_rx_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .clr_err(clr_err),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l));

    serial_rx_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin), .clr_err(clr_err),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line is driven freely between strobes to prove only strobed edges sample it.
    task automatic strobe(input logic b, input int gap);
        sin    = b;
        bit_en = 1'b1;
        tick(1);
        bit_en = 1'b0;
        for (int i = 0; i < gap; i++) begin
            sin = ~sin;
            tick(1);
        end
    endtask

    task automatic send_data(input logic [7:0] d, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < 8; i++) strobe(d[i], gap);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_data(d, 0);
        strobe(stop, 0);
        sin = 1'b1;
    endtask

    task automatic drain;
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_dout", dout_l, 8'h00);
        check("rst_valid", valid_l, 1'b0);
        check("rst_busy", busy_l, 1'b0);
        check("rst_flags", {ferr_l, ovr_l}, 2'b00);
        tick(1);
        rst = 1'b1;
        tick(2);

        dout_ready = 1'b1;
        send_data(8'h4D, 0);
        check("t1_busy_pre", busy_l, 1'b1);
        check("t1_valid_pre", valid_l, 1'b0);
        strobe(1'b1, 0);
        check("t1_dout", dout_l, 8'h4D);
        check("t1_valid", valid_l, 1'b1);
        check("t1_busy_post", busy_l, 1'b0);
        check("t1_flags", {ferr_l, ovr_l}, 2'b00);
        tick(1);
        check("t1_valid_1cyc", valid_l, 1'b0);

        send_data(8'h4D, 3);
        strobe(1'b1, 0);
        sin = 1'b1;
        check("t2_msb_dout", dout_m, 8'hB2);
        check("t2_msb_valid", valid_m, 1'b1);
        tick(1);
        dout_ready = 1'b0;

        send_frame(8'h3C, 1'b1);
        check("t3_dout1", dout_l, 8'h3C);
        check("t3_valid1", valid_l, 1'b1);
        send_frame(8'hF0, 1'b1);
        check("t3_dout_held", dout_l, 8'h3C);
        check("t3_valid2", valid_l, 1'b1);
        check("t3_overrun", ovr_l, 1'b1);
        drain();
        check("t3_consumed", valid_l, 1'b0);
        check("t3_ovr_sticky", ovr_l, 1'b1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t3_ovr_clr", ovr_l, 1'b0);

        send_frame(8'h55, 1'b0);
        check("t4_ferr", ferr_l, 1'b1);
        check("t4_valid", valid_l, 1'b0);
        check("t4_break_busy", busy_l, 1'b1);
        for (int i = 0; i < 20; i++) strobe(1'b0, 0);
        check("t4_low_busy", busy_l, 1'b1);
        check("t4_low_valid", valid_l, 1'b0);
        strobe(1'b1, 0);
        check("t4_idle", busy_l, 1'b0);
        send_frame(8'h81, 1'b1);
        check("t4_dout", dout_l, 8'h81);
        check("t4_valid2", valid_l, 1'b1);
        check("t4_ferr_sticky", ferr_l, 1'b1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("t4_ferr_clr", ferr_l, 1'b0);
        drain();

        send_frame(8'h11, 1'b1);
        check("t5_dout1", dout_l, 8'h11);
        send_data(8'h22, 0);
        dout_ready = 1'b1;
        strobe(1'b1, 0);
        dout_ready = 1'b0;
        sin = 1'b1;
        check("t5_dout2", dout_l, 8'h22);
        check("t5_valid", valid_l, 1'b1);
        check("t5_ovr", ovr_l, 1'b0);

        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(i[0], 0);
        rst = 1'b0;
        #2;
        check("t6_dout", dout_l, 8'h00);
        check("t6_valid", valid_l, 1'b0);
        check("t6_busy", busy_l, 1'b0);
        check("t6_flags", {ferr_l, ovr_l}, 2'b00);
        #2;
        rst = 1'b1;
        sin = 1'b1;
        tick(2);
        send_frame(8'h99, 1'b1);
        check("t6_dout2", dout_l, 8'h99);
        check("t6_valid2", valid_l, 1'b1);
        check("t6_ovr2", ovr_l, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
